// File: rtl/adc_sequencer_pkg.sv
// Shared types and sizing helpers for the ADC conversion sequencer.
package adc_pkg;

  // Width of one raw conversion result from the single-slope controller.
  localparam int unsigned ADC_COUNT_W = 8;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } adc_seq_state_e;

  // Accumulator width needed to sum 2^avg_log2 full-scale counts without overflow.
  function automatic int unsigned acc_width(input int unsigned avg_log2);
    return ADC_COUNT_W + avg_log2;
  endfunction

endpackage

// File: rtl/adc_sequencer_if.sv
// Handshake bundle between the sequencer (master) and the ADC controller (slave).
interface adc_sequencer_if;
  import adc_pkg::*;

  logic                   adc_restart;
  logic                   adc_busy;
  logic                   adc_valid;
  logic [ADC_COUNT_W-1:0] adc_count;

  modport master (
    output adc_restart,
    input  adc_busy,
    input  adc_valid,
    input  adc_count
  );

  modport slave (
    input  adc_restart,
    output adc_busy,
    output adc_valid,
    output adc_count
  );

endinterface

// File: rtl/adc_sequencer_watchdog.sv
// Per-conversion watchdog: counts enabled cycles since the last clear and
// flags expiry when the count reaches LIMIT-1.
module adc_watchdog #(
  parameter int unsigned LIMIT = 300
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt;

  assign expire = en && (cnt == CW'(LIMIT - 1));

  // Cycle counter; clear has priority so a fresh request always starts at zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_sequencer.sv
// Host-side requester for the single-slope ADC controller. Issues
// 2^AVG_LOG2 back-to-back conversions per request and emits their
// truncated mean as one sample. Optional per-conversion watchdog is
// enabled with the ADC_SEQ_TIMEOUT_EN macro; without it timeout_err is 0
// and the sequencer waits indefinitely for the controller.
module adc_sequencer
  import adc_pkg::*;
#(
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned TIMEOUT_CYC = 300
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   trig,
  input  logic                   cont_en,
  adc_sequencer_if.master        adc,
  output logic [ADC_COUNT_W-1:0] sample_data,
  output logic                   sample_valid,
  output logic                   overrun,
  output logic                   timeout_err
);

  localparam int unsigned ACC_W  = acc_width(AVG_LOG2);
  localparam int unsigned N_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned N_LAST = (1 << AVG_LOG2) - 1;

  adc_seq_state_e   state;
  adc_seq_state_e   state_next;
  logic [ACC_W-1:0] acc;
  logic [N_W-1:0]   n;
  logic             acc_clr;
  logic             acc_add;
  logic             last_conv;
  logic             wd_expire;

  // Mean of the accumulated counts; the shift truncates toward zero.
  function automatic logic [ADC_COUNT_W-1:0] mean_trunc(input logic [ACC_W-1:0] a);
    return ADC_COUNT_W'(a >> AVG_LOG2);
  endfunction

  assign last_conv = (n == N_W'(N_LAST));

`ifdef ADC_SEQ_TIMEOUT_EN
  logic wd_clr;
  logic wd_en;

  // Restart the watchdog on every fresh request, including REQ re-entry
  // between conversions, so the limit applies per conversion.
  assign wd_en  = (state == REQ) || (state == WAIT);
  assign wd_clr = (state_next == REQ) && (state != REQ);

  adc_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  // One-cycle error pulse, registered alongside the forced return to IDLE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_expire;
    end
  end
`else
  logic unused_timeout_cfg;

  assign wd_expire          = 1'b0;
  assign timeout_err        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and accumulator control; the watchdog overrides everything.
  always_comb begin
    state_next = state;
    acc_clr    = 1'b0;
    acc_add    = 1'b0;
    case (state)
      IDLE: begin
        if (trig || cont_en) begin
          state_next = REQ;
          acc_clr    = 1'b1;
        end
      end
      REQ: begin
        // A valid pulse here belongs to an earlier conversion and is ignored.
        if (adc.adc_busy) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (adc.adc_valid) begin
          acc_add    = 1'b1;
          state_next = last_conv ? OUT : REQ;
        end
      end
      OUT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (wd_expire) begin
      state_next = IDLE;
      acc_clr    = 1'b1;
      acc_add    = 1'b0;
    end
  end

  // Accumulator, request strobe and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc             <= '0;
      n               <= '0;
      adc.adc_restart <= 1'b0;
      sample_data     <= '0;
      sample_valid    <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      adc.adc_restart <= (state_next == REQ);
      sample_valid    <= (state == OUT);
      overrun         <= trig && (state != IDLE);
      if (state == OUT) begin
        sample_data <= mean_trunc(acc);
      end
      if (acc_clr) begin
        acc <= '0;
        n   <= '0;
      end else if (acc_add) begin
        acc <= acc + ACC_W'(adc.adc_count);
        n   <= n + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_sequencer.sv
// Bench for adc_sequencer: one instance averaging 4 conversions and one
// passing counts straight through, driven by a scripted ADC responder.
module tb_adc_sequencer;
  import adc_pkg::*;

  localparam int TMO = 50;

  logic       clk = 1'b0;
  logic       rstn, trig, cont_en, busy, valid, sel;
  logic [7:0] count;

  adc_sequencer_if if2 ();
  adc_sequencer_if if0 ();

  logic [7:0] data2, data0;
  logic       sv2, sv0, ov2, ov0, te2, te0;

  logic       restart_o, valid_o, ovr_o, tmo_o;
  logic [7:0] data_o;

  int tests = 0;
  int fails = 0;
  int req_cnt = 0, sv_cnt = 0, ovr_cnt = 0, tmo_cnt = 0;
  logic rs_prev = 1'b0;
  int s0, o0, r1, t;
  int q[$];

  always #5 clk = ~clk;

  assign if2.adc_busy  = sel & busy;
  assign if2.adc_valid = sel & valid;
  assign if2.adc_count = count;
  assign if0.adc_busy  = ~sel & busy;
  assign if0.adc_valid = ~sel & valid;
  assign if0.adc_count = count;

  assign restart_o = sel ? if2.adc_restart : if0.adc_restart;
  assign data_o    = sel ? data2 : data0;
  assign valid_o   = sel ? sv2 : sv0;
  assign ovr_o     = sel ? ov2 : ov0;
  assign tmo_o     = sel ? te2 : te0;

  adc_sequencer #(.AVG_LOG2(2), .TIMEOUT_CYC(TMO)) dut2 (
    .clk          (clk),
    .rstn         (rstn),
    .trig         (sel & trig),
    .cont_en      (sel & cont_en),
    .adc          (if2),
    .sample_data  (data2),
    .sample_valid (sv2),
    .overrun      (ov2),
    .timeout_err  (te2)
  );

  adc_sequencer #(.AVG_LOG2(0), .TIMEOUT_CYC(TMO)) dut0 (
    .clk          (clk),
    .rstn         (rstn),
    .trig         (~sel & trig),
    .cont_en      (~sel & cont_en),
    .adc          (if0),
    .sample_data  (data0),
    .sample_valid (sv0),
    .overrun      (ov0),
    .timeout_err  (te0)
  );

  // Event counters for the selected instance.
  always @(posedge clk) begin
    rs_prev <= restart_o;
    if (restart_o && !rs_prev) req_cnt <= req_cnt + 1;
    if (valid_o) sv_cnt <= sv_cnt + 1;
    if (ovr_o) ovr_cnt <= ovr_cnt + 1;
    if (tmo_o) tmo_cnt <= tmo_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: the sample is the plain sum of the counts divided by 2^l2, rounded down.
  function automatic int model_mean(input int cs[$], input int l2);
    int s = 0;
    foreach (cs[i]) s += cs[i];
    return s / (1 << l2);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("restart_latency", 32'(restart_o), 1);
  endtask

  // ADC responder for one conversion: answer the request, stay busy for
  // dur cycles, then return the count with a one-cycle valid.
  task automatic do_conv(input int c, input int dur, input bit stale, input bit ovr);
    int w = 0;
    while (restart_o !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("restart_request", 32'(restart_o), 1);
    if (stale) begin
      valid = 1'b1;
      count = 8'($urandom);
      @(negedge clk);
      valid = 1'b0;
      chk("restart_hold", 32'(restart_o), 1);
    end
    busy = 1'b1;
    @(negedge clk);
    chk("restart_drop", 32'(restart_o), 0);
    for (int i = 0; i < dur; i++) begin
      if (ovr && i == 0) trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      if (ovr && i == 0) chk("overrun_pulse", 32'(ovr_o), 1);
    end
    busy  = 1'b0;
    valid = 1'b1;
    count = 8'(c);
    @(negedge clk);
    valid = 1'b0;
  endtask

  // One full averaged sample after the request has been issued.
  task automatic run_seq(input int l2, input int cs[$], input bit ovr);
    int r0 = req_cnt;
    foreach (cs[i]) do_conv(cs[i], $urandom_range(1, 5), 1'($urandom_range(0, 1)), ovr && i == 1);
    chk("sv_not_early", 32'(valid_o), 0);
    @(negedge clk);
    chk("sv_two_after", 32'(valid_o), 1);
    chk("mean", 32'(data_o), model_mean(cs, l2));
    chk("requests", req_cnt - r0, cs.size());
  endtask

  initial begin
    sel = 1'b1; rstn = 1'b0; trig = 1'b0; cont_en = 1'b0;
    busy = 1'b0; valid = 1'b0; count = 8'd0;
    idle(3);
    chk("rst_restart2", 32'(if2.adc_restart), 0);
    chk("rst_data2", 32'(data2), 0);
    chk("rst_sv2", 32'(sv2), 0);
    chk("rst_ovr2", 32'(ov2), 0);
    chk("rst_tmo2", 32'(te2), 0);
    chk("rst_state2", 32'(dut2.state), 32'(IDLE));
    chk("rst_restart0", 32'(if0.adc_restart), 0);
    chk("rst_data0", 32'(data0), 0);
    chk("rst_sv0", 32'(sv0), 0);
    rstn = 1'b1;
    idle(2);

    // Directed average: 10+20+30+41 = 101, 101>>2 = 25
    s0 = sv_cnt;
    pulse_trig();
    q = '{10, 20, 30, 41};
    run_seq(2, q, 1'b0);
    idle(3);
    chk("sv_single", sv_cnt - s0, 1);
    chk("sv_low_after", 32'(valid_o), 0);
    chk("data_held", 32'(data_o), 25);

    // Random averages; first one also gets a trig during WAIT
    for (int it = 0; it < 3; it++) begin
      s0 = sv_cnt;
      o0 = ovr_cnt;
      q = {};
      for (int k = 0; k < 4; k++) q.push_back(int'($urandom_range(0, 255)));
      pulse_trig();
      run_seq(2, q, it == 0);
      idle(3);
      chk("rand_sv_single", sv_cnt - s0, 1);
      chk("rand_overrun_cnt", ovr_cnt - o0, (it == 0) ? 1 : 0);
    end

    // Reset during the third conversion, coinciding with adc_valid
    s0 = sv_cnt;
    pulse_trig();
    do_conv(50, 2, 1'b0, 1'b0);
    do_conv(60, 2, 1'b0, 1'b0);
    chk("mid_req", 32'(restart_o), 1);
    busy = 1'b1;
    @(negedge clk);
    valid = 1'b1; count = 8'd200; rstn = 1'b0;
    @(negedge clk);
    valid = 1'b0; busy = 1'b0; rstn = 1'b1;
    chk("midrst_restart", 32'(restart_o), 0);
    chk("midrst_data", 32'(data_o), 0);
    chk("midrst_sv", 32'(valid_o), 0);
    chk("midrst_ovr", 32'(ovr_o), 0);
    chk("midrst_state", 32'(dut2.state), 32'(IDLE));
    @(negedge clk);
    chk("midrst_stays_idle", 32'(restart_o), 0);
    chk("midrst_no_sample", sv_cnt - s0, 0);
    q = {};
    for (int k = 0; k < 4; k++) q.push_back(int'($urandom_range(0, 255)));
    pulse_trig();
    run_seq(2, q, 1'b0);
    idle(3);

    // Pass-through instance, free-running with extremes
    sel = 1'b0;
    idle(2);
    s0 = sv_cnt;
    o0 = ovr_cnt;
    trig = 1'b1; cont_en = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("cont_restart", 32'(restart_o), 1);
    q = '{255};
    run_seq(0, q, 1'b0);
    chk("idle_gap", 32'(restart_o), 0);
    @(negedge clk);
    chk("cont_next_req", 32'(restart_o), 1);
    cont_en = 1'b0;
    q = '{0};
    run_seq(0, q, 1'b0);
    r1 = req_cnt;
    idle(6);
    chk("cont_stopped", req_cnt - r1, 0);
    chk("cont_restart_low", 32'(restart_o), 0);
    chk("cont_samples", sv_cnt - s0, 2);
    chk("trig_with_cont_no_ovr", ovr_cnt - o0, 0);

`ifdef ADC_SEQ_TIMEOUT_EN
    // Controller never answers: watchdog must abort the sequence
    sel = 1'b1;
    idle(2);
    s0 = sv_cnt;
    pulse_trig();
    t = 0;
    while (tmo_o !== 1'b1 && t < 200) begin
      if (t == 2) busy = 1'b1;
      @(negedge clk);
      t++;
    end
    chk("timeout_cycle", t, TMO);
    chk("timeout_restart", 32'(restart_o), 0);
    chk("timeout_state", 32'(dut2.state), 32'(IDLE));
    busy = 1'b0;
    @(negedge clk);
    chk("timeout_single", 32'(tmo_o), 0);
    idle(3);
    chk("timeout_no_sample", sv_cnt - s0, 0);
    chk("timeout_count", tmo_cnt, 1);
`else
    chk("timeout_never", tmo_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
